// File: rtl/dram_controller_banked.sv
`default_nettype none
// ============================================================================
// Module      : dram_controller_banked
// Description : FPM DRAM controller for a 68000 bus. It handles multi-bank
//               SIMMs, a programmable address window, configurable CAS wait
//               states, and CAS-before-RAS refresh with a pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_controller_banked #(
    parameter int          ROW_BITS    = 11,
    parameter int          BANK_BITS   = 1,
    parameter logic [23:0] BASE_ADDR   = 24'h100000,
    parameter int          REFRESH_CNT = 100,
    parameter int          CAS_WAIT    = 1,
    parameter int          RAS_HOLD    = 2,
    parameter int          PRECHARGE   = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      AS,
    input  logic                      UDS,
    input  logic                      LDS,
    input  logic                      RW,
    input  logic [23:0]               ADDR_IN,
    output logic [ROW_BITS-1:0]       ADDR_OUT,
    output logic [(2**BANK_BITS)-1:0] RAS,
    output logic                      CAS_LOWER,
    output logic                      CAS_UPPER,
    output logic                      WE,
    output logic                      OE,
    output logic                      DTACK_DRAM,
    output logic                      REFRESH_BUSY
);

    localparam int          c_num_banks = 2**BANK_BITS;
    // Address bits spanned by the whole window: bank + row + column + byte.
    localparam int          c_win_bits  = 2*ROW_BITS + 1 + BANK_BITS;
    localparam logic [11:0] c_ref_last  = 12'(REFRESH_CNT - 1);
    localparam logic [2:0]  c_cas_wait  = 3'(CAS_WAIT);
    localparam logic [2:0]  c_ras_hold  = 3'(RAS_HOLD);
    localparam logic [2:0]  c_precharge = 3'(PRECHARGE);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RAS_ON   = 4'd1,
        S_COL      = 4'd2,
        S_CAS_ON   = 4'd3,
        S_WAIT     = 4'd4,
        S_ACK      = 4'd5,
        S_REF_CAS  = 4'd6,
        S_REF_RAS  = 4'd7,
        S_REF_HOLD = 4'd8,
        S_PRE      = 4'd9
    } state_t;

    state_t                 r_state;
    logic [11:0]            r_ref_cnt;
    logic                   r_pending;
    logic [2:0]             r_cnt;
    logic                   r_abort;
    logic [BANK_BITS-1:0]   r_bank;
    logic [ROW_BITS-1:0]    r_col;
    logic [ROW_BITS-1:0]    r_addr;
    logic [c_num_banks-1:0] r_ras;
    logic                   r_cas_l;
    logic                   r_cas_u;
    logic                   r_we;
    logic                   r_oe;
    logic                   r_dtack;
    logic                   r_busy;

    logic [31:0]            w_addr_ext;
    logic [31:0]            w_base_ext;
    logic [31:0]            w_off;
    logic                   w_in_window;
    logic                   w_sel;
    logic                   w_expire;
    logic                   w_ref_req;
    logic                   w_take_ref;
    logic [ROW_BITS-1:0]    w_row;
    logic [ROW_BITS-1:0]    w_col;
    logic [BANK_BITS-1:0]   w_bank;
    logic                   w_unused_ok;

    // Window decode is done in 32 bits so a window running past the top
    // of the 24-bit CPU space does not wrap around.
    assign w_addr_ext  = {8'h00, ADDR_IN};
    assign w_base_ext  = {8'h00, BASE_ADDR};
    assign w_off       = w_addr_ext - w_base_ext;
    assign w_in_window = (w_addr_ext >= w_base_ext) && ((w_off >> c_win_bits) == 32'd0);
    assign w_sel       = ~AS & w_in_window;
    assign w_col       = w_off[ROW_BITS:1];
    assign w_row       = w_off[2*ROW_BITS:ROW_BITS+1];
    assign w_bank      = w_off[2*ROW_BITS+BANK_BITS:2*ROW_BITS+1];
    assign w_unused_ok = w_off[0];

    // An expiry on the same clock as an IDLE select already counts as a request.
    assign w_expire   = (r_ref_cnt == c_ref_last);
    assign w_ref_req  = r_pending | w_expire;
    assign w_take_ref = (r_state == S_IDLE) && w_ref_req;

    // Free-running refresh timer with a single-entry pending flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ref_cnt <= 12'd0;
            r_pending <= 1'b0;
        end else begin
            if (w_expire) r_ref_cnt <= 12'd0;
            else          r_ref_cnt <= r_ref_cnt + 12'd1;
            if (w_take_ref)    r_pending <= 1'b0;
            else if (w_expire) r_pending <= 1'b1;
        end
    end

    // Access / refresh sequencer. All DRAM strobes are registered here.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_abort <= 1'b0;
            r_bank  <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_ras   <= '1;
            r_cas_l <= 1'b1;
            r_cas_u <= 1'b1;
            r_we    <= 1'b1;
            r_oe    <= 1'b1;
            r_dtack <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_ref_req) begin
                        r_state <= S_REF_CAS;
                    end else if (w_sel) begin
                        r_addr  <= w_row;
                        r_col   <= w_col;
                        r_bank  <= w_bank;
                        r_we    <= RW;
                        r_state <= S_RAS_ON;
                    end
                end
                S_RAS_ON: begin
                    if (AS) r_abort <= 1'b1;
                    r_ras[r_bank] <= 1'b0;
                    r_state       <= S_COL;
                end
                S_COL: begin
                    if (AS) r_abort <= 1'b1;
                    r_addr  <= r_col;
                    r_state <= S_CAS_ON;
                end
                S_CAS_ON: begin
                    if (AS) r_abort <= 1'b1;
                    r_cas_u <= UDS;
                    r_cas_l <= LDS;
                    r_oe    <= ~RW;
                    r_cnt   <= c_cas_wait;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A wait of 0 or 1 both acknowledge on the clock after CAS.
                    if (r_cnt <= 3'd1) begin
                        if (r_abort || AS) begin
                            // Bus cycle already gone: close without DTACK.
                            r_ras   <= '1;
                            r_cas_l <= 1'b1;
                            r_cas_u <= 1'b1;
                            r_we    <= 1'b1;
                            r_oe    <= 1'b1;
                            r_addr  <= '0;
                            r_cnt   <= c_precharge;
                            r_state <= S_PRE;
                        end else begin
                            r_dtack <= 1'b0;
                            r_state <= S_ACK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_ACK: begin
                    if (AS) begin
                        r_ras   <= '1;
                        r_cas_l <= 1'b1;
                        r_cas_u <= 1'b1;
                        r_we    <= 1'b1;
                        r_oe    <= 1'b1;
                        r_dtack <= 1'b1;
                        r_addr  <= '0;
                        r_cnt   <= c_precharge;
                        r_state <= S_PRE;
                    end
                end
                S_REF_CAS: begin
                    r_cas_l <= 1'b0;
                    r_cas_u <= 1'b0;
                    r_we    <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= S_REF_RAS;
                end
                S_REF_RAS: begin
                    r_ras   <= '0;
                    r_cnt   <= c_ras_hold;
                    r_state <= S_REF_HOLD;
                end
                S_REF_HOLD: begin
                    if (r_cnt <= 3'd1) begin
                        r_ras   <= '1;
                        r_cas_l <= 1'b1;
                        r_cas_u <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= c_precharge;
                        r_state <= S_PRE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_PRE: begin
                    if (r_cnt <= 3'd1) r_state <= S_IDLE;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ADDR_OUT     = r_addr;
    assign RAS          = r_ras;
    assign CAS_LOWER    = r_cas_l;
    assign CAS_UPPER    = r_cas_u;
    assign WE           = r_we;
    assign OE           = r_oe;
    assign DTACK_DRAM   = r_dtack;
    assign REFRESH_BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dram_controller_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_controller_banked
// Description : Directed self-checking bench for dram_controller_banked.
//               Three instances share one CPU bus: the default timing, then
//               CAS_WAIT=0 and CAS_WAIT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_controller_banked;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        AS  = 1'b1;
    logic        UDS = 1'b1;
    logic        LDS = 1'b1;
    logic        RW  = 1'b1;
    logic [23:0] ADDR_IN = 24'h0;

    logic [10:0] m_addr, z_addr, t_addr;
    logic [1:0]  m_ras, z_ras, t_ras;
    logic        m_cl, m_cu, m_we, m_oe, m_dt, m_busy;
    logic        z_cl, z_cu, z_we, z_oe, z_dt, z_busy;
    logic        t_cl, t_cu, t_we, t_oe, t_dt, t_busy;

    int n_checks = 0;
    int n_err    = 0;

    dram_controller_banked u_dut (
        .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .ADDR_IN(ADDR_IN), .ADDR_OUT(m_addr), .RAS(m_ras),
        .CAS_LOWER(m_cl), .CAS_UPPER(m_cu), .WE(m_we), .OE(m_oe),
        .DTACK_DRAM(m_dt), .REFRESH_BUSY(m_busy)
    );

    dram_controller_banked #(.CAS_WAIT(0)) u_dut_cw0 (
        .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .ADDR_IN(ADDR_IN), .ADDR_OUT(z_addr), .RAS(z_ras),
        .CAS_LOWER(z_cl), .CAS_UPPER(z_cu), .WE(z_we), .OE(z_oe),
        .DTACK_DRAM(z_dt), .REFRESH_BUSY(z_busy)
    );

    dram_controller_banked #(.CAS_WAIT(3)) u_dut_cw3 (
        .CLK(CLK), .RST(RST), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
        .ADDR_IN(ADDR_IN), .ADDR_OUT(t_addr), .RAS(t_ras),
        .CAS_LOWER(t_cl), .CAS_UPPER(t_cu), .WE(t_we), .OE(t_oe),
        .DTACK_DRAM(t_dt), .REFRESH_BUSY(t_busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1; ADDR_IN = 24'h0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic start_access(input logic [23:0] a, input logic rw, input logic u, input logic l);
        ADDR_IN = a; RW = rw; UDS = u; LDS = l; AS = 1'b0;
    endtask

    task automatic end_access();
        AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    endtask

    int  busy_rise, busy_ticks, rasl_ticks, first_cas, first_ras;
    int  f_busy, f_rasl, f_m, f_z, f_t;
    logic prev_busy, inv_bad, act_bad;

    initial begin
        // Reset values
        tick();
        chk("rst_addr", m_addr, 11'h0);
        chk("rst_ras", m_ras, 2'b11);
        chk("rst_cas", {m_cu, m_cl}, 2'b11);
        chk("rst_we_oe", {m_we, m_oe}, 2'b11);
        chk("rst_dtack", m_dt, 1'b1);
        chk("rst_busy", m_busy, 1'b0);

        // Word read at the base address
        do_reset();
        repeat (3) tick();
        start_access(24'h100000, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rd_n1_ras_high", m_ras, 2'b11);
        tick();
        chk("rd_ras_bank0", m_ras, 2'b10);
        chk("rd_row", m_addr, 11'h0);
        chk("rd_we", m_we, 1'b1);
        tick();
        chk("rd_cas_after_ras", {m_cu, m_cl}, 2'b11);
        tick();
        chk("rd_cas", {m_cu, m_cl}, 2'b00);
        chk("rd_oe", m_oe, 1'b0);
        chk("rd_dtack_wait", m_dt, 1'b1);
        chk("cw0_dtack_wait", z_dt, 1'b1);
        tick();
        chk("rd_dtack", m_dt, 1'b0);
        chk("cw0_dtack", z_dt, 1'b0);
        chk("cw3_dtack_n5", t_dt, 1'b1);
        tick();
        chk("cw3_dtack_n6", t_dt, 1'b1);
        tick();
        chk("cw3_dtack_n7", t_dt, 1'b0);
        end_access();
        tick();
        chk("rd_release", {m_ras, m_cu, m_cl, m_we, m_oe, m_dt}, 7'b11_11111);
        chk("rd_release_addr", m_addr, 11'h0);

        // Lower-byte write to bank 1, row 0, column 0
        do_reset();
        repeat (3) tick();
        start_access(24'h900001, 1'b0, 1'b1, 1'b0);
        tick();
        chk("wr_we", m_we, 1'b0);
        tick();
        chk("wr_ras_bank1", m_ras, 2'b01);
        tick();
        chk("wr_col", m_addr, 11'h0);
        tick();
        chk("wr_cas_lower_only", {m_cu, m_cl}, 2'b10);
        chk("wr_oe", m_oe, 1'b1);
        tick();
        chk("wr_dtack", m_dt, 1'b0);
        end_access();
        tick();
        chk("wr_release_we", m_we, 1'b1);

        // Row/column multiplexing with non-zero fields
        do_reset();
        repeat (3) tick();
        start_access(24'h3AA2AA, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mux_row", m_addr, 11'h2AA);
        tick();
        chk("mux_ras_bank0", m_ras, 2'b10);
        tick();
        chk("mux_col", m_addr, 11'h155);
        repeat (2) tick();
        end_access();
        tick();

        // Off-window addresses must not touch the DRAM
        do_reset();
        repeat (3) tick();
        act_bad = 1'b0;
        start_access(24'h0FFFFE, 1'b1, 1'b0, 1'b0);
        repeat (8) begin
            tick();
            if (m_ras != 2'b11 || !m_cu || !m_cl || !m_dt) act_bad = 1'b1;
        end
        chk("offwin_0FFFFE", act_bad, 1'b0);
        end_access();
        tick();
        act_bad = 1'b0;
        start_access(24'h000000, 1'b1, 1'b0, 1'b0);
        repeat (8) begin
            tick();
            if (m_ras != 2'b11 || !m_cu || !m_cl || !m_dt) act_bad = 1'b1;
        end
        chk("offwin_000000", act_bad, 1'b0);
        end_access();
        tick();

        // Idle refresh cadence
        do_reset();
        busy_rise = 0; busy_ticks = 0; rasl_ticks = 0; first_cas = -1; first_ras = -1;
        prev_busy = 1'b0; inv_bad = 1'b0;
        for (int t = 1; t <= 210; t++) begin
            tick();
            if (m_busy && !prev_busy) busy_rise++;
            if (m_busy) busy_ticks++;
            if (!m_cu && !m_cl && first_cas < 0) first_cas = t;
            if (m_ras == 2'b00) begin
                rasl_ticks++;
                if (first_ras < 0) first_ras = t;
                if (m_cu || m_cl) inv_bad = 1'b1;
            end
            prev_busy = m_busy;
        end
        chk("ref_count", busy_rise, 2);
        chk("ref_first_cas", first_cas, 101);
        chk("ref_first_ras", first_ras, 102);
        chk("ref_ras_low_ticks", rasl_ticks, 4);
        chk("ref_busy_ticks", busy_ticks, 6);
        chk("ref_cbr_order", inv_bad, 1'b0);

        // Refresh expiry collides with a select in IDLE
        do_reset();
        repeat (99) tick();
        start_access(24'h100000, 1'b1, 1'b0, 1'b0);
        f_busy = -1; f_rasl = -1; f_m = -1; f_z = -1; f_t = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (m_busy && f_busy < 0) f_busy = n;
            if (m_ras == 2'b00 && f_rasl < 0) f_rasl = n;
            if (!m_dt && f_m < 0) f_m = n;
            if (!z_dt && f_z < 0) f_z = n;
            if (!t_dt && f_t < 0) f_t = n;
        end
        chk("col_refresh_first", f_busy, 2);
        chk("col_ras_all_low", f_rasl, 3);
        chk("col_dtack_cw1", f_m, 12);
        chk("col_dtack_cw0", f_z, 12);
        chk("col_dtack_cw3", f_t, 14);
        end_access();
        repeat (4) tick();

        // Asynchronous reset while acknowledging
        do_reset();
        repeat (3) tick();
        start_access(24'h3AA2AA, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        chk("ack_before_reset", m_dt, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk("arst_ras", m_ras, 2'b11);
        chk("arst_cas", {m_cu, m_cl}, 2'b11);
        chk("arst_oe_dtack", {m_oe, m_dt}, 2'b11);
        chk("arst_addr", m_addr, 11'h0);
        end_access();
        tick();
        tick();
        RST = 1'b1;
        repeat (2) tick();
        start_access(24'h100000, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        chk("post_rst_ras", m_ras, 2'b10);
        repeat (3) tick();
        chk("post_rst_dtack", m_dt, 1'b0);
        end_access();
        tick();
        chk("post_rst_release", m_dt, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
